// File: rtl/flappy_pkg.sv
// Shared constants, game state encoding and helpers for the scrolling-column game logic.
package flappy_pkg;

  localparam int unsigned SCREEN_WIDTH  = 640;
  localparam int unsigned SCREEN_HEIGHT = 480;
  localparam int unsigned COL_WIDTH     = 40;
  localparam int unsigned BIRD_X        = 160;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } game_state_e;

  // Four-digit BCD increment, saturating at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v != 16'h9999) begin
      for (int unsigned d = 0; d < 4; d++) begin
        if (c) begin
          if (r[d*4 +: 4] == 4'd9) begin
            r[d*4 +: 4] = 4'd0;
          end else begin
            r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/column_gen_multi_if.sv
// Column geometry bus from the column generator to the renderer/collision logic.
interface column_gen_multi_if #(
  parameter int unsigned NUM_COLS = 4,
  parameter int unsigned X_W      = 11
);
  logic [NUM_COLS*X_W-1:0] col_x;
  logic [NUM_COLS*X_W-1:0] col_y;
  logic [NUM_COLS-1:0]     col_valid;

  modport master (output col_x, output col_y, output col_valid);
  modport slave  (input  col_x, input  col_y, input  col_valid);
endinterface

// File: rtl/gap_lfsr.sv
// 16-bit Galois LFSR (right shift) exposing its low OUT_W bits for gap heights.
module gap_lfsr
  import flappy_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [OUT_W-1:0] value
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/column_gen_multi.sv
// Scrolling column generator: NUM_COLS columns, random gaps, pass detection,
// BCD score, speed ramp and the IDLE/RUN/FROZEN game state machine.
module column_gen_multi
  import flappy_pkg::game_state_e, flappy_pkg::IDLE, flappy_pkg::RUN,
         flappy_pkg::FROZEN, flappy_pkg::bcd_inc;
#(
  parameter int unsigned NUM_COLS       = 4,
  parameter int unsigned X_W            = 11,
  parameter int unsigned SCREEN_WIDTH   = flappy_pkg::SCREEN_WIDTH,
  parameter int unsigned COL_SPACING    = 200,
  parameter int unsigned COL_WIDTH      = flappy_pkg::COL_WIDTH,
  parameter int unsigned BIRD_X         = flappy_pkg::BIRD_X,
  parameter int unsigned GAP_MIN        = 96,
  parameter int unsigned GAP_RANGE_LOG2 = 8,
  parameter int unsigned SPEED_INIT     = 2,
  parameter int unsigned SPEED_MAX      = 6,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic               gameClk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               finished,
  column_gen_multi_if.master cols,
  output logic               pass_pulse,
  output logic [15:0]        score_bcd,
  output logic [3:0]         speed,
  output logic               running
);

  localparam int unsigned   XE    = X_W + 1;
  localparam logic [XE-1:0] SPAN  = XE'(NUM_COLS * COL_SPACING);
  localparam logic [XE-1:0] CW_E  = XE'(COL_WIDTH);
  localparam logic [XE-1:0] BX_E  = XE'(BIRD_X);
  localparam logic [X_W-1:0] Y_MID = X_W'(GAP_MIN + (2 ** (GAP_RANGE_LOG2 - 1)));

  game_state_e                        state_q, state_d;
  logic [NUM_COLS-1:0][X_W-1:0]       col_x_q, col_x_d;
  logic [NUM_COLS-1:0][X_W-1:0]       col_y_q, col_y_d;
  logic [NUM_COLS-1:0]                valid_q, valid_d;
  logic                               pass_q, pass_d;
  logic [15:0]                        score_q, score_d;
  logic [3:0]                         speed_q, speed_d;
  logic [NUM_COLS-1:0]                respawn, pass_vec;
  logic [XE-1:0]                      x, nx, spd;
  logic [GAP_RANGE_LOG2-1:0]          lfsr_low;

  gap_lfsr #(
    .SEED (LFSR_SEED),
    .OUT_W(GAP_RANGE_LOG2)
  ) u_lfsr (
    .clk  (gameClk),
    .rst_n(reset_n),
    .en   (1'b1),
    .value(lfsr_low)
  );

  always_comb begin
    state_d  = state_q;
    col_x_d  = col_x_q;
    col_y_d  = col_y_q;
    valid_d  = valid_q;
    pass_d   = 1'b0;
    score_d  = score_q;
    speed_d  = speed_q;
    respawn  = '0;
    pass_vec = '0;
    x        = '0;
    nx       = '0;
    spd      = XE'(speed_q);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          valid_d = '1;
        end
      end
      RUN: begin
        if (finished) begin
          state_d = FROZEN;
        end else begin
          for (int unsigned i = 0; i < NUM_COLS; i++) begin
            x = {1'b0, col_x_q[i]};
            if (x < spd) begin
              respawn[i] = 1'b1;
              nx         = x + SPAN - spd;
              col_y_d[i] = X_W'(GAP_MIN) + X_W'(lfsr_low);
            end else begin
              nx = x - spd;
              if ((x + CW_E >= BX_E) && (nx + CW_E < BX_E)) pass_vec[i] = 1'b1;
            end
            col_x_d[i] = nx[X_W-1:0];
          end
          if (|pass_vec) begin
            pass_d  = 1'b1;
            score_d = bcd_inc(score_q);
            // Ones digit wraps only when not saturated at 9999.
            if (score_q[3:0] == 4'd9 && score_q != 16'h9999)
              speed_d = (speed_q >= 4'(SPEED_MAX)) ? 4'(SPEED_MAX) : speed_q + 4'd1;
          end
        end
      end
      FROZEN: begin
        if (start) begin
          state_d = RUN;
          for (int unsigned i = 0; i < NUM_COLS; i++) begin
            col_x_d[i] = X_W'(SCREEN_WIDTH + i * COL_SPACING);
            col_y_d[i] = Y_MID;
          end
          score_d = '0;
          speed_d = 4'(SPEED_INIT);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gameClk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      for (int unsigned i = 0; i < NUM_COLS; i++) begin
        col_x_q[i] <= X_W'(SCREEN_WIDTH + i * COL_SPACING);
        col_y_q[i] <= Y_MID;
      end
      valid_q <= '0;
      pass_q  <= 1'b0;
      score_q <= '0;
      speed_q <= 4'(SPEED_INIT);
    end else begin
      state_q <= state_d;
      col_x_q <= col_x_d;
      col_y_q <= col_y_d;
      valid_q <= valid_d;
      pass_q  <= pass_d;
      score_q <= score_d;
      speed_q <= speed_d;
    end
  end

  // Column spacing must keep respawns and passes to one per tick.
  always_ff @(posedge gameClk) begin
    if (reset_n && state_q == RUN && !finished) begin
      assert ($countones(respawn) <= 1);
      assert ($countones(pass_vec) <= 1);
    end
  end

  assign cols.col_x     = col_x_q;
  assign cols.col_y     = col_y_q;
  assign cols.col_valid = valid_q;
  assign pass_pulse     = pass_q;
  assign score_bcd      = score_q;
  assign speed          = speed_q;
  assign running        = (state_q == RUN);

endmodule

// File: tb/tb_column_gen_multi.sv
// Directed bench for column_gen_multi: vector table for the state machine plus
// hand sequences for pass timing, respawn, score/speed ramp, freeze and async reset.
module tb_column_gen_multi;

  logic        gameClk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        finished;
  logic        pass_pulse;
  logic [15:0] score_bcd;
  logic [3:0]  speed;
  logic        running;

  int checks = 0;
  int errors = 0;

  column_gen_multi_if #(.NUM_COLS(4), .X_W(11)) cif ();

  column_gen_multi #(.NUM_COLS(4), .X_W(11)) dut (
    .gameClk   (gameClk),
    .reset_n   (reset_n),
    .start     (start),
    .finished  (finished),
    .cols      (cif),
    .pass_pulse(pass_pulse),
    .score_bcd (score_bcd),
    .speed     (speed),
    .running   (running)
  );

  always #5 gameClk = ~gameClk;

  // Reference LFSR: Galois, taps 0xB400, advancing every tick out of reset.
  logic [15:0] m_lfsr;
  always @(posedge gameClk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  typedef struct {
    logic        start;
    logic        finished;
    logic        running;
    logic [3:0]  valid;
    logic [10:0] x0;
    logic [10:0] x3;
    logic        pass;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [10:0] colx(input int i);
    return cif.col_x[i*11 +: 11];
  endfunction

  function automatic logic [10:0] coly(input int i);
    return cif.col_y[i*11 +: 11];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge gameClk);
    @(negedge gameClk);
  endtask

  task automatic wait_pass(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 600 && !seen; n++) begin
      step();
      if (pass_pulse) seen = 1'b1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_x0"}, colx(0), 640);
    check({tag, "_x1"}, colx(1), 840);
    check({tag, "_x2"}, colx(2), 1040);
    check({tag, "_x3"}, colx(3), 1240);
    for (int i = 0; i < 4; i++) check($sformatf("%s_y%0d", tag, i), coly(i), 224);
    check({tag, "_score"}, score_bcd, 16'h0000);
    check({tag, "_speed"}, speed, 2);
    check({tag, "_valid"}, cif.col_valid, 4'b0000);
    check({tag, "_running"}, running, 0);
    check({tag, "_pass"}, pass_pulse, 0);
  endtask

  initial begin
    bit          seen;
    bit          nopass;
    logic [15:0] pre;

    // start, finished -> running, valid, x0, x3, pass
    vecs[0] = '{1'b0, 1'b0, 1'b0, 4'h0, 11'd640, 11'd1240, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 4'hF, 11'd640, 11'd1240, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 4'hF, 11'd638, 11'd1238, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 4'hF, 11'd636, 11'd1236, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 4'hF, 11'd636, 11'd1236, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 4'hF, 11'd636, 11'd1236, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 4'hF, 11'd640, 11'd1240, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 4'hF, 11'd638, 11'd1238, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 4'hF, 11'd638, 11'd1238, 1'b0};

    reset_n  = 1'b0;
    start    = 1'b0;
    finished = 1'b0;
    repeat (2) @(negedge gameClk);
    check_reset_values("rst");
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      start    = vecs[i].start;
      finished = vecs[i].finished;
      step();
      check($sformatf("vec%0d_running", i), running, vecs[i].running);
      check($sformatf("vec%0d_valid", i), cif.col_valid, vecs[i].valid);
      check($sformatf("vec%0d_x0", i), colx(0), vecs[i].x0);
      check($sformatf("vec%0d_x3", i), colx(3), vecs[i].x3);
      check($sformatf("vec%0d_pass", i), pass_pulse, vecs[i].pass);
    end
    start    = 1'b0;
    finished = 1'b0;

    // Async reset in the middle of a RUN tick period.
    start = 1'b1; step(); start = 1'b0;
    step();
    check("pre_arst_x0", colx(0), 638);
    #3 reset_n = 1'b0;
    #1 check_reset_values("arst");
    @(negedge gameClk);
    reset_n = 1'b1;

    // Free run from start: column 0 passes the bird on RUN tick 261.
    start = 1'b1; step(); start = 1'b0;
    check("run_running", running, 1);
    check("run_x0_t0", colx(0), 640);
    nopass = 1'b1;
    for (int t = 1; t <= 260; t++) begin
      step();
      if (pass_pulse) nopass = 1'b0;
    end
    check("no_early_pass", nopass, 1);
    check("x0_t260", colx(0), 120);
    step();
    check("x0_t261", colx(0), 118);
    check("pass_t261", pass_pulse, 1);
    check("score_t261", score_bcd, 16'h0001);
    step();
    check("pass_t262", pass_pulse, 0);
    check("score_t262", score_bcd, 16'h0001);
    for (int t = 263; t <= 320; t++) step();
    check("x0_t320", colx(0), 0);
    pre = m_lfsr;
    step();
    check("x0_t321", colx(0), 798);
    check("y0_t321", colx(0) == 798 ? coly(0) : 11'd0, 11'(96 + pre[7:0]));

    wait_pass(seen);
    check("pass2_seen", seen, 1);
    check("score2", score_bcd, 16'h0002);
    check("speed2", speed, 2);

    // Score preloaded to 0009 so each pass wraps the ones digit.
    for (int k = 0; k < 5; k++) begin
      force dut.score_q = 16'h0009;
      step();
      release dut.score_q;
      check($sformatf("force%0d_score", k), score_bcd, 16'h0009);
      wait_pass(seen);
      check($sformatf("ramp%0d_seen", k), seen, 1);
      check($sformatf("ramp%0d_score", k), score_bcd, 16'h0010);
      check($sformatf("ramp%0d_speed", k), speed, (k + 3 > 6) ? 6 : k + 3);
    end

    force dut.score_q = 16'h9999;
    step();
    release dut.score_q;
    wait_pass(seen);
    check("sat_seen", seen, 1);
    check("sat_score", score_bcd, 16'h9999);
    check("sat_speed", speed, 6);
    step();
    check("sat_pass_width", pass_pulse, 0);

    // finished beats start in RUN.
    finished = 1'b1; start = 1'b1;
    step();
    finished = 1'b0;
    check("frz_running", running, 0);
    check("frz_pass", pass_pulse, 0);
    check("frz_score", score_bcd, 16'h9999);
    step();
    start = 1'b0;
    check("restart_running", running, 1);
    check("restart_x0", colx(0), 640);
    check("restart_x3", colx(3), 1240);
    check("restart_score", score_bcd, 16'h0000);
    check("restart_speed", speed, 2);
    check("restart_valid", cif.col_valid, 4'hF);
    repeat (5) step();
    check("pre_frz_x0", colx(0), 630);
    finished = 1'b1;
    step();
    check("frz2_running", running, 0);
    check("frz2_x0", colx(0), 630);
    for (int n = 0; n < 50; n++) begin
      finished = n[0];
      step();
      check($sformatf("hold%0d_x0", n), colx(0), 630);
      check($sformatf("hold%0d_x3", n), colx(3), 1230);
      check($sformatf("hold%0d_valid", n), cif.col_valid, 4'hF);
      check($sformatf("hold%0d_pass", n), pass_pulse, 0);
      check($sformatf("hold%0d_running", n), running, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
